ysyx_22040237_mem_arb: RTL and testbench
========================================

# ysyx_22040237_mem_arb

Two-requester memory arbiter that shares the single memory port of the CPU between the instruction-fetch side (IFU) and the load/store side (LSU). It sits between the core (pc_reg/ifu fetch path and exu load/store path) and the memory model. It accepts one transaction at a time over valid/ready handshakes, forwards it to memory, and routes the response back to the owning requester. Arbitration is LSU-priority, with a starvation guard for the IFU.

## Interface
- STARVE_LIM, 4: consecutive LSU grants with the IFU waiting before the IFU is forced to win; range 1..15.
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ifu_req_valid  input  1  IFU fetch request.
- ifu_req_ready  output  1  IFU request accepted this cycle.
- ifu_addr  input  32  fetch address.
- ifu_rsp_valid  output  1  one-cycle pulse; ifu_rsp_data is valid.
- ifu_rsp_data  output  64  fetched data.
- lsu_req_valid  input  1  LSU request.
- lsu_req_ready  output  1  LSU request accepted this cycle.
- lsu_addr  input  32  access address.
- lsu_wen  input  1  1 = write, 0 = read.
- lsu_wdata  input  64  write data.
- lsu_wmask  input  8  byte write mask.
- lsu_rsp_valid  output  1  one-cycle pulse; read data or write acknowledge.
- lsu_rsp_data  output  64  read data. Holds the previous value on a write acknowledge.
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts the request.
- mem_addr  output  32  latched address.
- mem_wen  output  1  latched write enable. Forced to 0 for IFU transactions.
- mem_wdata  output  64  latched write data.
- mem_wmask  output  8  latched mask. Forced to 0 for IFU transactions.
- mem_rsp_valid  input  1  memory response. Every request, including writes, receives exactly one.
- mem_rdata  input  64  response data.
- busy  output  1  a transaction is outstanding (state is not IDLE).

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE arbitration** (combinational):
  - Only LSU valid: LSU wins.
  - Only IFU valid: IFU wins.
  - Both valid: LSU wins, unless starve_cnt == STARVE_LIM, in which case IFU wins.
  - Only the winner sees its req_ready = 1. Both readies are 0 outside IDLE.
- **IDLE, handshake** (valid & ready):
  - Latch owner, addr, wen, wdata and wmask into the mem_* registers.
  - For an IFU win, mem_wen and mem_wmask are latched as 0.
  - Go to REQ.
- **REQ:** mem_req_valid = 1, with mem_* fields stable. When mem_req_ready = 1, go to WAIT.
- **WAIT:** mem_req_valid = 0. When mem_rsp_valid = 1:
  - Register mem_rdata into the owner's rsp_data; for an LSU write, lsu_rsp_data is not updated.
  - Pulse the owner's rsp_valid for exactly one cycle.
  - Go to IDLE.
- mem_rsp_valid in IDLE or REQ is ignored; no state change and no output change.
- **starve_cnt** (4-bit):
  - On an LSU grant with ifu_req_valid = 1: increment, saturating at STARVE_LIM.
  - On any IFU grant, or an LSU grant with ifu_req_valid = 0: clear to 0.
  - Otherwise: hold.
- A requester holds valid and its fields until it receives ready. Dropping valid before ready is permitted; no grant results.

## Timing
- Reset (rst = 0, asynchronous), all outputs and registers:
  - state = IDLE, starve_cnt = 0, owner = IFU.
  - mem_req_valid, mem_wen = 0; mem_addr, mem_wdata, mem_wmask = 0.
  - ifu_rsp_valid, lsu_rsp_valid = 0; ifu_rsp_data, lsu_rsp_data = 0.
  - busy = 0.
- Reset mid-transaction aborts it with no response pulse. The memory side must also be reset.
- **Latency** (memory ready immediately, response one cycle after acceptance):
  - Cycle 0: handshake.
  - Cycle 1: mem_req_valid = 1 and accepted.
  - Cycle 2: mem_rsp_valid.
  - Cycle 3: requester rsp_valid pulse; the FSM is already in IDLE and can accept the next request in the same cycle.
  - Minimum issue interval: 3 cycles.
- A mem_req_valid stall of any length holds the REQ state with fields unchanged.
- Back-to-back: a response pulse for one requester and a grant to the other in the same cycle is legal and required.

## Test plan
- IFU read only: ifu_addr = 0x80000000, mem_rdata = 0x00100073 returned one cycle after acceptance. Expect:
  - ifu_req_ready in cycle 0.
  - mem_req_valid in cycle 1 with mem_wen = 0.
  - ifu_rsp_valid pulse in cycle 3 with ifu_rsp_data = 0x00100073.
  - lsu_rsp_valid stays 0.
- Simultaneous requests with starve_cnt = 0: expect the LSU granted first, then the IFU granted in the IDLE cycle after the LSU response, then starve_cnt returns to 0.
- Starvation guard, STARVE_LIM = 4: IFU and LSU both continuously valid. Expect grant order LSU, LSU, LSU, LSU, IFU, LSU…
- LSU write: addr 0x80001000, wdata 0x1122334455667788, wmask 0x0F. Expect:
  - mem_* fields match the inputs while in REQ.
  - lsu_rsp_valid pulses once.
  - lsu_rsp_data is unchanged.
- Memory stall of 5 cycles on mem_req_ready, plus a stray mem_rsp_valid during REQ. Expect:
  - Fields remain stable throughout the stall.
  - The stray response is ignored.
  - Exactly one rsp_valid pulse, after the real response.
- rst asserted while in WAIT: busy = 0, mem_req_valid = 0 and rsp_valid = 0 immediately (asynchronously); after release, a new IFU request completes normally.

Source files
------------

// File: rtl/ysyx_22040237_mem_arb.sv
`timescale 1ns/1ps
// ysyx_22040237_mem_arb
// Shares the single memory port between instruction fetch (IFU) and
// load/store (LSU). One transaction is in flight at a time:
//   IDLE --grant--> REQ --mem_req_ready--> WAIT --mem_rsp_valid--> IDLE
// LSU has priority; after STARVE_LIM consecutive LSU grants while the IFU
// was waiting, the IFU is forced to win the next contested arbitration.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ifu_req_* / ifu_rsp_*  fetch request (addr) and 64-bit response pulse
//   lsu_req_* / lsu_rsp_*  load/store request (addr, wen, wdata, wmask)
//                          and response pulse (read data or write ack)
//   mem_req_* / mem_rsp_*  memory port; mem_* fields are registered
//   busy                a transaction is outstanding
module ysyx_22040237_mem_arb #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [63:0] ifu_rsp_data,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [63:0] lsu_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [3:0] LIM = STARVE_LIM[3:0];

  logic [1:0] state;
  logic [3:0] starve_cnt;
  logic       owner;
  logic       idle;
  logic       ifu_forced;
  logic       lsu_win;
  logic       ifu_win;
  logic       lsu_hs;
  logic       ifu_hs;

  // Arbitration is purely combinational on the current valids; the IFU
  // only overrides the LSU when it is itself requesting and has waited out
  // STARVE_LIM LSU grants.
  assign idle          = (state == S_IDLE);
  assign ifu_forced    = ifu_req_valid && (starve_cnt == LIM);
  assign lsu_win       = lsu_req_valid && !ifu_forced;
  assign ifu_win       = ifu_req_valid && !lsu_win;
  assign lsu_req_ready = idle && lsu_win;
  assign ifu_req_ready = idle && ifu_win;
  assign lsu_hs        = lsu_req_valid && lsu_req_ready;
  assign ifu_hs        = ifu_req_valid && ifu_req_ready;

  assign mem_req_valid = (state == S_REQ);
  assign busy          = !idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      owner         <= OWN_IFU;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= '0;
      lsu_rsp_data  <= '0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lsu_hs) begin
            owner     <= OWN_LSU;
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wdata;
            mem_wmask <= lsu_wmask;
            state     <= S_REQ;
          end else if (ifu_hs) begin
            // Fetches are always reads: no write enable, no mask, no data.
            owner     <= OWN_IFU;
            mem_addr  <= ifu_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            state <= S_IDLE;
            if (owner == OWN_LSU) begin
              lsu_rsp_valid <= 1'b1;
              // A write ack carries no data; keep the last load result.
              if (!mem_wen) lsu_rsp_data <= mem_rdata;
            end else begin
              ifu_rsp_valid <= 1'b1;
              ifu_rsp_data  <= mem_rdata;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Counts LSU wins taken while the IFU was also asking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (lsu_hs) begin
      if (!ifu_req_valid)         starve_cnt <= '0;
      else if (starve_cnt != LIM) starve_cnt <= starve_cnt + 4'd1;
    end else if (ifu_hs) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
`timescale 1ns/1ps
module tb_ysyx_22040237_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr;
  logic [63:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr;
  logic [63:0] lsu_wdata, lsu_rsp_data;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  ysyx_22040237_mem_arb #(.STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          own;    // 1 = LSU
    logic [63:0] data;
    int          gcyc;
    int          lat;    // -1 = latency not checked
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  exp_t        sb[$];
  req_t        ifu_q[$];
  req_t        lsu_q[$];
  bit          glog_own[$];
  int          glog_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_lat = -1;
  int          stall_cfg = 0;
  int          rsp_delay = 0;
  bit          stray_cfg = 1'b0;
  logic [63:0] last_lsu;

  function automatic logic [63:0] rdata_of(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0000_0010_0073;
    return {~a, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // IFU requester: holds valid until the handshake edge, pushes the expected
  // response into the scoreboard when it sees ready.
  initial begin : ifu_drv
    bit hs;
    hs = 1'b0;
    ifu_req_valid = 1'b0;
    ifu_addr = '0;
    forever begin
      exp_t e;
      @(negedge clk);
      if (hs) begin ifu_req_valid = 1'b0; hs = 1'b0; end
      if (!rst) ifu_req_valid = 1'b0;
      else begin
        if (!ifu_req_valid && ifu_q.size() > 0) begin
          ifu_addr = ifu_q[0].addr;
          ifu_req_valid = 1'b1;
        end
        #1;
        if (ifu_req_valid && ifu_req_ready) begin
          e.own = 1'b0; e.data = rdata_of(ifu_addr); e.gcyc = cyc + 1; e.lat = exp_lat;
          sb.push_back(e);
          glog_own.push_back(1'b0); glog_cyc.push_back(cyc + 1);
          ifu_q.delete(0);
          hs = 1'b1;
        end
      end
    end
  end

  // LSU requester. Idle fields are deliberately write-like so an IFU grant
  // that wrongly latched them would show up on mem_wen/mem_wmask.
  initial begin : lsu_drv
    bit hs;
    hs = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_addr = '0;
    lsu_wen = 1'b1;
    lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    lsu_wmask = 8'hFF;
    last_lsu = '0;
    forever begin
      exp_t e;
      @(negedge clk);
      if (hs) begin lsu_req_valid = 1'b0; hs = 1'b0; end
      if (!rst) begin lsu_req_valid = 1'b0; last_lsu = '0; end
      else begin
        if (!lsu_req_valid && lsu_q.size() > 0) begin
          lsu_addr  = lsu_q[0].addr;
          lsu_wen   = lsu_q[0].wen;
          lsu_wdata = lsu_q[0].wdata;
          lsu_wmask = lsu_q[0].wmask;
          lsu_req_valid = 1'b1;
        end
        #1;
        if (lsu_req_valid && lsu_req_ready) begin
          if (!lsu_wen) last_lsu = rdata_of(lsu_addr);
          e.own = 1'b1; e.data = last_lsu; e.gcyc = cyc + 1; e.lat = exp_lat;
          sb.push_back(e);
          glog_own.push_back(1'b1); glog_cyc.push_back(cyc + 1);
          lsu_q.delete(0);
          hs = 1'b1;
        end
      end
    end
  end

  // Memory model: optional accept stall (with one stray response while
  // stalled) and optional extra response delay after acceptance.
  initial begin : mem_model
    bit acc, in_req;
    int stall_left, dly_left;
    logic [31:0] acc_addr;
    acc = 1'b0; in_req = 1'b0; stall_left = 0; dly_left = 0; acc_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (!rst) begin
        mem_req_ready = 1'b0; acc = 1'b0; in_req = 1'b0;
      end else begin
        if (mem_req_ready) begin
          mem_req_ready = 1'b0; acc = 1'b1; in_req = 1'b0;
          dly_left = rsp_delay; acc_addr = mem_addr;
        end
        if (acc) begin
          if (dly_left == 0) begin
            mem_rsp_valid = 1'b1; mem_rdata = rdata_of(acc_addr); acc = 1'b0;
          end else dly_left--;
        end else if (mem_req_valid) begin
          if (!in_req) begin in_req = 1'b1; stall_left = stall_cfg; end
          if (stall_left > 0) begin
            stall_left--;
            if (stray_cfg && stall_left == 2) begin
              mem_rsp_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
          end else mem_req_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: pops one expectation per response pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) sb.delete();
      else if (ifu_rsp_valid || lsu_rsp_valid) begin
        chk("rsp_overlap", 64'(ifu_rsp_valid & lsu_rsp_valid), 64'd0);
        if (sb.size() == 0) chk("unexpected_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_owner", 64'(lsu_rsp_valid), 64'(e.own));
          chk("rsp_data", e.own ? lsu_rsp_data : ifu_rsp_data, e.data);
          if (e.lat >= 0) chk("rsp_latency", 64'(cyc - e.gcyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((ifu_q.size() > 0 || lsu_q.size() > 0 || sb.size() > 0 || busy ||
            ifu_req_valid || lsu_req_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk(name, 64'(n), 64'(budget - 1));
    @(posedge clk);
  endtask

  // Checks mem_* fields on every REQ cycle and the number of REQ cycles.
  task automatic wait_req_check(input logic [31:0] a, input logic w, input logic [63:0] d,
                                input logic [7:0] m, input bit chk_d, input int exp_cycles);
    int n, k;
    n = 0; k = 0;
    while (!mem_req_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("req_timeout", 64'(n), 64'd0);
    while (mem_req_valid && k < 50) begin
      chk("mem_addr", 64'(mem_addr), 64'(a));
      chk("mem_wen", 64'(mem_wen), 64'(w));
      chk("mem_wmask", 64'(mem_wmask), 64'(m));
      if (chk_d) chk("mem_wdata", mem_wdata, d);
      @(negedge clk);
      k++;
    end
    chk("req_cycles", 64'(k), 64'(exp_cycles));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit exp_own[6];
    req_t r;
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wen_wmask", 64'({mem_wen, mem_wmask}), 64'd0);
    chk("rst_rsp_valid", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    chk("rst_ifu_rsp_data", ifu_rsp_data, 64'd0);
    chk("rst_lsu_rsp_data", lsu_rsp_data, 64'd0);
    rst = 1'b1;
    @(posedge clk);

    // IFU read, minimum latency; LSU idle fields look like a write
    exp_lat = 2;
    r = '{32'h8000_0000, 1'b0, 64'd0, 8'd0};
    ifu_q.push_back(r);
    wait_req_check(32'h8000_0000, 1'b0, 64'd0, 8'h00, 1'b0, 1);
    wait_idle("ifu_read_timeout", 50);
    chk("ifu_rsp_data_hold", ifu_rsp_data, 64'h0000_0000_0010_0073);

    // Simultaneous: LSU first, IFU granted in the response cycle
    glog_own.delete(); glog_cyc.delete();
    r = '{32'h8000_0100, 1'b0, 64'd0, 8'd0}; lsu_q.push_back(r);
    r = '{32'h8000_0200, 1'b0, 64'd0, 8'd0}; ifu_q.push_back(r);
    wait_idle("simul_timeout", 50);
    chk("simul_grants", 64'(glog_own.size()), 64'd2);
    if (glog_own.size() == 2) begin
      chk("simul_first", 64'(glog_own[0]), 64'd1);
      chk("simul_second", 64'(glog_own[1]), 64'd0);
      chk("simul_gap", 64'(glog_cyc[1] - glog_cyc[0]), 64'd3);
    end

    // Starvation guard: LSU x4, IFU, LSU
    glog_own.delete(); glog_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      r = '{32'h8000_0300 + 32'(i * 8), 1'b0, 64'd0, 8'd0};
      lsu_q.push_back(r);
    end
    r = '{32'h8000_0400, 1'b0, 64'd0, 8'd0}; ifu_q.push_back(r);
    wait_idle("starve_timeout", 200);
    chk("starve_grants", 64'(glog_own.size()), 64'd6);
    if (glog_own.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("starve_order[%0d]", i), 64'(glog_own[i]), 64'(exp_own[i]));
        if (i > 0) chk($sformatf("starve_gap[%0d]", i), 64'(glog_cyc[i] - glog_cyc[i-1]), 64'd3);
      end
    end

    // LSU write with a 2-cycle accept stall; lsu_rsp_data must hold
    exp_lat = 4; stall_cfg = 2;
    r = '{32'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F};
    lsu_q.push_back(r);
    wait_req_check(32'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 1'b1, 3);
    wait_idle("write_timeout", 50);
    chk("write_hold_data", lsu_rsp_data, {~32'h8000_0320, 32'h8000_0320});

    // 5-cycle stall with a stray response during REQ
    exp_lat = 7; stall_cfg = 5; stray_cfg = 1'b1;
    r = '{32'h8000_2000, 1'b0, 64'd0, 8'd0};
    lsu_q.push_back(r);
    wait_req_check(32'h8000_2000, 1'b0, 64'd0, 8'h00, 1'b0, 6);
    wait_idle("stall_timeout", 50);
    stall_cfg = 0; stray_cfg = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while in WAIT, then a normal fetch
    exp_lat = -1; rsp_delay = 3;
    r = '{32'h8000_3000, 1'b0, 64'd0, 8'd0};
    ifu_q.push_back(r);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(busy && !mem_req_valid) && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("wait_state_timeout", 64'(n), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("arst_rsp_valid", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    chk("arst_mem_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(negedge clk);
    rsp_delay = 0;
    rst = 1'b1;
    @(posedge clk);
    exp_lat = 2;
    r = '{32'h8000_4000, 1'b0, 64'd0, 8'd0};
    ifu_q.push_back(r);
    wait_idle("post_rst_timeout", 50);
    chk("post_rst_ifu_data", ifu_rsp_data, {~32'h8000_4000, 32'h8000_4000});

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
